mul_seq: RTL



---
 rtl/mul_pkg.sv | 13 +
 rtl/mul_seq_step.sv | 19 +
 rtl/mul_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encodings and the default operand width.
package mul_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq_step.sv
// One add-and-shift slice of the multiplier datapath: conditionally adds
// the multiplicand into the accumulator and shifts the multiplicand left.
module mul_seq_step #(
  parameter int PW = 10
) (
  input  logic [PW-1:0] acc,
  input  logic [PW-1:0] mcand,
  input  logic          mplier_lsb,
  output logic [PW-1:0] acc_next,
  output logic [PW-1:0] mcand_next
);

  // Add when the current multiplier bit is set; multiplicand moves up one weight.
  always_comb begin
    acc_next   = mplier_lsb ? (acc + mcand) : acc;
    mcand_next = mcand << 1;
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one product
// per WIDTH+1 cycles.
// Optional feature: define MUL_SEQ_SIGNED_EN for two's-complement operands
// (sign-magnitude internally, result negated on the last RUN edge).
//
// Handshake: start is sampled only in IDLE or DONE; an accepted start
// captures a/b on that edge. busy is high exactly in RUN, done is a
// one-cycle pulse in DONE during which p is valid. p holds until the next
// result is written. start during RUN is ignored, not queued.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   count;
  logic [PW-1:0]   acc_next;
  logic [PW-1:0]   mcand_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]   result;
  logic            accept;
  logic            last_run;

  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_run = (state_q == ST_RUN) && (count == CW'(WIDTH - 1));
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

`ifdef MUL_SEQ_SIGNED_EN
  logic sign;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    a_mag  = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    b_mag  = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    result = sign ? (~acc_next + PW'(1)) : acc_next;
  end

  // Sign flag captured alongside the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign <= 1'b0;
    end else if (accept) begin
      sign <= a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  // Unsigned build: operands and result pass through unchanged.
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    result = acc_next;
  end
`endif

  mul_seq_step #(.PW(PW)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier_lsb (mplier[0]),
    .acc_next   (acc_next),
    .mcand_next (mcand_next)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE accepts a new start directly for back-to-back use.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (count == CW'(WIDTH - 1)) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: load on accept, step every RUN cycle, publish on the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      p      <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      count  <= '0;
    end else if (state_q == ST_RUN) begin
      acc    <= acc_next;
      mcand  <= mcand_next;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (last_run) begin
        p <= result;
      end
    end
  end

endmodule
